// File: rtl/seg_display_reader.sv
// Two-digit seven-segment monitor: waits for a stable {seg1,seg0} pattern and reports it once as BCD and binary.
// Optional SEG_READER_ERRCNT_EN adds a saturating err_count output.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | watching for a pattern different from the last one decoded
// ST_SETTLE  | candidate captured, counting consecutive identical samples
// ST_OUTPUT  | decoded result presented, waiting for out_ready

module seg_display_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones,
  output logic [6:0] out_value,
  output logic       err
`ifdef SEG_READER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] s_q, s_d;
  logic [13:0] cand_q, cand_d;
  logic [13:0] last_pat_q, last_pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_tens_q, out_tens_d;
  logic [3:0]  out_ones_q, out_ones_d;
  logic [6:0]  out_value_q, out_value_d;
  logic        err_q, err_d;

  // Returns {valid, digit}; blank is not a digit here, the tens path adds it.
  function automatic logic [4:0] dec_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7D:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h6F:   r = {1'b1, 4'd9};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [4:0] dec_tens, dec_ones;
  logic       tens_ok, ones_ok;
  logic [6:0] tens_ext, ones_ext;

  always_comb begin
    dec_tens = dec_seg(cand_q[13:7]);
    dec_ones = dec_seg(cand_q[6:0]);
    tens_ok  = dec_tens[4] || (cand_q[13:7] == 7'h00);
    ones_ok  = dec_ones[4];
    tens_ext = {3'b000, dec_tens[3:0]};
    ones_ext = {3'b000, dec_ones[3:0]};
  end

  always_comb begin
    s_d         = {seg1, seg0};
    state_d     = state_q;
    cand_d      = cand_q;
    last_pat_d  = last_pat_q;
    cnt_d       = cnt_q;
    out_tens_d  = out_tens_q;
    out_ones_d  = out_ones_q;
    out_value_d = out_value_q;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_q != last_pat_q) begin
          cand_d  = s_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s_q != cand_q) begin
          cand_d = s_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          last_pat_d = cand_q;
          if (tens_ok && ones_ok) begin
            out_tens_d  = dec_tens[3:0];
            out_ones_d  = dec_ones[3:0];
            out_value_d = (tens_ext << 3) + (tens_ext << 1) + ones_ext;
            state_d     = ST_OUTPUT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OUTPUT: begin
        // Result is frozen here; segment changes are picked up from IDLE afterwards.
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= 14'h0000;
      cand_q      <= 14'h0000;
      last_pat_q  <= 14'h0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_tens_q  <= 4'd0;
      out_ones_q  <= 4'd0;
      out_value_q <= 7'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cand_q      <= cand_d;
      last_pat_q  <= last_pat_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_tens_q  <= out_tens_d;
      out_ones_q  <= out_ones_d;
      out_value_q <= out_value_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tens  = out_tens_q;
  assign out_ones  = out_ones_q;
  assign out_value = out_value_q;
  assign err       = err_q;

`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
